// File: rtl/axi_wslv_pkg.sv
// ---------------------------------------------------------------------------
// axi_wslv_pkg
// Shared definitions for the AXI4 write-channel responder (axi_write_slave)
// and its burst address generator (axi_burst_addr_gen).
//   - burst type encodings as they appear on axi_awburst
//   - write response encodings driven on axi_bresp
//   - responder FSM state type
//   - default largest legal awsize for a 64-bit data bus
//   - helper that recognises the burst lengths a WRAP burst may use
// ---------------------------------------------------------------------------
package axi_wslv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_MAX_SIZE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wslv_state_t;

  // A WRAP burst must cover 2, 4, 8 or 16 beats so that the wrap boundary
  // is a power of two multiple of the beat size.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Purely combinational next-beat address calculation for an AXI4 burst.
//   cur_addr     in   AW  address of the beat being accepted now
//   start_addr   in   AW  captured awaddr (used for the WRAP base)
//   len          in   8   captured awlen (beats minus one)
//   size         in   3   captured awsize, already clamped to the bus width
//   burst        in   2   captured awburst
//   next_addr    out  AW  address of the following beat
//   illegal_wrap out  1   WRAP burst with a length that cannot wrap
// FIXED holds the address, INCR aligns and steps by the beat size (wrapping
// modulo 2^AW), WRAP steps inside the (len+1)*bytes window.  Reserved bursts
// and WRAP bursts with an illegal length fall back to INCR stepping.
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_wslv_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] cur_addr,
  input  logic [AW-1:0] start_addr,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          illegal_wrap
);

  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] aligned_cur;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] wrap_base;

  // Step arithmetic shared by every burst type.  Aligning the current
  // address first makes an unaligned first beat land on the next aligned
  // beat, while later beats are already aligned and step unchanged.
  always_comb begin
    beat_bytes  = AW'(1) << size;
    aligned_cur = cur_addr & ~(beat_bytes - AW'(1));
    incr_addr   = aligned_cur + beat_bytes;
    wrap_mask   = ((AW'(len) + AW'(1)) << size) - AW'(1);
    wrap_base   = start_addr & ~wrap_mask;
  end

  // Burst type selection.  A WRAP step that reaches the boundary drops its
  // low bits to zero, which the OR with the window base turns into the wrap.
  always_comb begin
    next_addr    = incr_addr;
    illegal_wrap = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = wrap_base | (incr_addr & wrap_mask);
        end else begin
          illegal_wrap = 1'b1;
        end
      end
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_write_slave.sv
// ---------------------------------------------------------------------------
// axi_write_slave
// AXI4 write-channel responder.  Accepts one AW burst at a time, takes the W
// beats, presents each beat on a simple memory write port and then returns
// the B response.
//   clk, rst            clock, asynchronous active-high reset
//   axi_aw*             write address channel (addr/len/size/burst/valid/ready)
//   axi_w*              write data channel (data/strb/last/valid/ready)
//   axi_b*              write response channel (resp/valid/ready)
//   mem_we              one-cycle pulse per accepted beat
//   mem_addr/wdata/wstrb beat address, data and strobes
//   proto_err           sticky protocol-violation flag, cleared only by rst
// Optional build macro AXI_WSLV_SLVERR_EN: when defined, a burst that saw any
// protocol error (or a beat with all strobes low) answers SLVERR; otherwise
// bresp is always OKAY.
// ---------------------------------------------------------------------------
module axi_write_slave
  import axi_wslv_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int MAX_SIZE = DEF_MAX_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  output logic            proto_err
);

  wslv_state_t   state;
  wslv_state_t   state_nxt;

  logic          awready_nxt;
  logic          wready_nxt;
  logic          bvalid_nxt;

  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          last_beat;
  logic          wlast_err;
  logic          size_err;
  logic          cfg_err;
  logic [2:0]    size_clamped;

  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_len;
  logic [2:0]    cap_size;
  logic [1:0]    cap_burst;
  logic [7:0]    beat_cnt;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic          illegal_wrap;

  // Handshakes use the registered ready/valid outputs, so each one can only
  // fire in the state that owns that channel.  The final beat is decided by
  // the captured length alone; wlast is only compared against it.
  assign aw_hs        = axi_awvalid & axi_awready;
  assign w_hs         = axi_wvalid & axi_wready;
  assign b_hs         = axi_bvalid & axi_bready;
  assign last_beat    = (beat_cnt == cap_len);
  assign wlast_err    = w_hs & (axi_wlast != last_beat);
  assign size_err     = (axi_awsize > 3'(MAX_SIZE));
  assign cfg_err      = size_err | (axi_awburst == BURST_RSVD);
  assign size_clamped = size_err ? 3'(MAX_SIZE) : axi_awsize;

  axi_burst_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .cur_addr    (cur_addr),
    .start_addr  (cap_addr),
    .len         (cap_len),
    .size        (cap_size),
    .burst       (cap_burst),
    .next_addr   (next_addr),
    .illegal_wrap(illegal_wrap)
  );

  // State register.  Reset drops straight back to IDLE so an interrupted
  // burst never produces a response or further memory writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one burst in flight, address -> data -> response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (aw_hs)             state_nxt = ST_DATA;
      ST_DATA: if (w_hs && last_beat) state_nxt = ST_RESP;
      ST_RESP: if (b_hs)              state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the channel handshake signals
  // can be registered and still line up with the state they belong to.
  always_comb begin
    awready_nxt = (state_nxt == ST_IDLE);
    wready_nxt  = (state_nxt == ST_DATA);
    bvalid_nxt  = (state_nxt == ST_RESP);
  end

  // Registered channel handshake outputs.  All are low during reset, and
  // awready comes up on the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
    end else begin
      axi_awready <= awready_nxt;
      axi_wready  <= wready_nxt;
      axi_bvalid  <= bvalid_nxt;
    end
  end

  // Burst datapath: capture the AW fields, walk the beat address, drive the
  // memory port one cycle after each W handshake, and latch protocol errors.
  // Reserved burst types are stored as-is; the address generator steps them
  // like INCR.  An illegal WRAP length is flagged while the burst is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_len   <= '0;
      cap_size  <= '0;
      cap_burst <= '0;
      beat_cnt  <= '0;
      cur_addr  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      proto_err <= 1'b0;
    end else begin
      mem_we <= w_hs;
      if (aw_hs) begin
        cap_addr  <= axi_awaddr;
        cap_len   <= axi_awlen;
        cap_size  <= size_clamped;
        cap_burst <= axi_awburst;
        cur_addr  <= axi_awaddr;
        beat_cnt  <= '0;
        if (cfg_err) begin
          proto_err <= 1'b1;
        end
      end
      if (w_hs) begin
        mem_addr  <= cur_addr;
        mem_wdata <= axi_wdata;
        mem_wstrb <= axi_wstrb;
        cur_addr  <= next_addr;
        beat_cnt  <= beat_cnt + 8'd1;
      end
      if (wlast_err || (state == ST_DATA && illegal_wrap)) begin
        proto_err <= 1'b1;
      end
    end
  end

`ifdef AXI_WSLV_SLVERR_EN
  logic burst_err;
  logic strb_err;

  assign strb_err = w_hs & (axi_wstrb == '0);

  // Per-burst error tracking for the SLVERR response.  The bit restarts at
  // each address handshake (seeded with any address-phase error) and the
  // final beat's own errors are folded in when the response is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_err <= 1'b0;
      axi_bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        burst_err <= cfg_err;
      end else if (wlast_err || strb_err || (state == ST_DATA && illegal_wrap)) begin
        burst_err <= 1'b1;
      end
      if (w_hs && last_beat) begin
        axi_bresp <= (burst_err || wlast_err || strb_err || illegal_wrap) ?
                     RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        axi_bresp <= RESP_OKAY;
      end
    end
  end
`else
  assign axi_bresp = RESP_OKAY;
`endif

endmodule
